// File: rtl/sort_12_drain.sv
// sort_12_drain: output-side streamer for the 12-input sorting network.
// Captures one sorted 12-word frame in a single cycle, then streams it out one
// word per valid/ready beat, rank 0 first, with first/last/index sideband.
//
// Optional feature macro: SORT_DRAIN_CHECK_EN
//   defined   -> adjacent-order check at capture; order_err flags a frame whose
//                words were not non-decreasing (unsigned), on its last beat.
//   undefined -> no comparators; order_err is tied to 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   frame handshake (in_ready combinational from out_ready)
//   sort_0..sort_11     sorted frame words, sort_0 = rank 0
//   out_valid/out_ready word stream handshake
//   out_data            current word
//   out_index           rank of current word (0..11)
//   out_first/out_last  rank 0 / rank 11 markers
//   order_err           frame order violation flag (last beat only)
module sort_12_drain #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sort_0,
  input  logic [WIDTH-1:0] sort_1,
  input  logic [WIDTH-1:0] sort_2,
  input  logic [WIDTH-1:0] sort_3,
  input  logic [WIDTH-1:0] sort_4,
  input  logic [WIDTH-1:0] sort_5,
  input  logic [WIDTH-1:0] sort_6,
  input  logic [WIDTH-1:0] sort_7,
  input  logic [WIDTH-1:0] sort_8,
  input  logic [WIDTH-1:0] sort_9,
  input  logic [WIDTH-1:0] sort_10,
  input  logic [WIDTH-1:0] sort_11,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_index,
  output logic             out_first,
  output logic             out_last,
  output logic             order_err
);

  localparam int unsigned NWORDS   = 12;
  localparam int unsigned IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_nxt;
  logic [WIDTH-1:0] buffer   [NWORDS];
  logic [WIDTH-1:0] frame_in [NWORDS];
  logic [WIDTH-1:0] word_sel;
  logic             at_last;
  logic             capture;
  logic             beat;

  // Gather the parallel sorter outputs into an indexable frame.
  assign frame_in[0]  = sort_0;
  assign frame_in[1]  = sort_1;
  assign frame_in[2]  = sort_2;
  assign frame_in[3]  = sort_3;
  assign frame_in[4]  = sort_4;
  assign frame_in[5]  = sort_5;
  assign frame_in[6]  = sort_6;
  assign frame_in[7]  = sort_7;
  assign frame_in[8]  = sort_8;
  assign frame_in[9]  = sort_9;
  assign frame_in[10] = sort_10;
  assign frame_in[11] = sort_11;

  // Word select; index never exceeds LAST_IDX so unmatched codes cannot occur.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      if (index == IDX_W'(i)) word_sel = buffer[i];
    end
  end

  // Next-state, handshakes and registered-state-derived outputs.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    at_last   = (index == LAST_IDX);
    out_valid = (state == DRAIN);
    // Last-beat bypass: a new frame may load as the final word leaves.
    in_ready  = !rst && ((state == IDLE) || (out_ready && at_last));
    capture   = in_valid && in_ready;
    beat      = out_valid && out_ready;

    unique case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = DRAIN;
          index_nxt = '0;
        end
      end
      DRAIN: begin
        if (beat) begin
          if (at_last) begin
            index_nxt = '0;
            state_nxt = capture ? DRAIN : IDLE;
          end else begin
            index_nxt = index + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase

    out_data  = out_valid ? word_sel : '0;
    out_index = out_valid ? index : '0;
    out_first = out_valid && (index == '0);
    out_last  = out_valid && at_last;
  end

  // State, index and frame buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      for (int i = 0; i < int'(NWORDS); i++) buffer[i] <= '0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      if (capture) begin
        for (int i = 0; i < int'(NWORDS); i++) buffer[i] <= frame_in[i];
      end
    end
  end

`ifdef SORT_DRAIN_CHECK_EN
  logic frame_bad;
  logic frame_err;

  // Adjacent unsigned order check on the incoming frame.
  always_comb begin
    frame_bad = 1'b0;
    for (int i = 0; i < int'(NWORDS) - 1; i++) begin
      if (frame_in[i] > frame_in[i+1]) frame_bad = 1'b1;
    end
  end

  // Error bit follows the frame currently held in the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (capture) begin
      frame_err <= frame_bad;
    end
  end

  assign order_err = frame_err && out_valid && out_last;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_12_drain.sv
// Bench for sort_12_drain: scoreboard of expected beats pushed at capture and
// popped at each accepted beat. Inputs change and outputs are sampled mid-cycle.
module tb_sort_12_drain;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_index;
  logic        out_first;
  logic        out_last;
  logic        order_err;
  logic [31:0] sv [12];
  logic        exp_rdy;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  idx;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  sort_12_drain #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sort_0(sv[0]), .sort_1(sv[1]), .sort_2(sv[2]), .sort_3(sv[3]),
    .sort_4(sv[4]), .sort_5(sv[5]), .sort_6(sv[6]), .sort_7(sv[7]),
    .sort_8(sv[8]), .sort_9(sv[9]), .sort_10(sv[10]), .sort_11(sv[11]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .out_first(out_first), .out_last(out_last), .order_err(order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of a capture: 12 expected beats, with the frame-order error bit.
  task automatic push_frame();
    logic bad;
    exp_t e;
    bad = 1'b0;
    for (int i = 0; i < 11; i++) if (sv[i] > sv[i+1]) bad = 1'b1;
`ifndef SORT_DRAIN_CHECK_EN
    bad = 1'b0;
`endif
    for (int i = 0; i < 12; i++) begin
      e.d = sv[i]; e.idx = 4'(i); e.err = bad;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) sv[i] = 32'(i);
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_hold c=%0d got rdy=%b vld=%b data=%0d exp 0 0 0", c, in_ready, out_valid, out_data);
      end
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 4'd0 || order_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b vld=%b idx=%0d err=%b exp 1 0 0 0", in_ready, out_valid, out_index, order_err);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    q.delete();
    for (int c = 0; c < 14; c++) begin
      in_valid = (c == 0); out_ready = 1'b1;
      if (c == 0) for (int i = 0; i < 12; i++) sv[i] = 32'(10 * i);
      #1;
      exp_rdy = !rst && (!out_valid || (out_ready && q.size() > 0 && q[0].idx == 4'd11));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL single_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_index !== q[0].idx || out_first !== (q[0].idx == 4'd0) ||
            out_last !== (q[0].idx == 4'd11) || order_err !== (q[0].err && q[0].idx == 4'd11)) begin
          failures++;
          $display("FAIL single_beat c=%0d got d=%0d i=%0d f=%b l=%b e=%b exp d=%0d i=%0d", c, out_data, out_index, out_first, out_last, order_err, q[0].d, q[0].idx);
        end
        if (out_ready) void'(q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_index !== 4'd0 || out_first !== 1'b0 || out_last !== 1'b0 || order_err !== 1'b0) begin
          failures++;
          $display("FAIL single_idle c=%0d got vld=%b i=%0d f=%b l=%b e=%b exp all 0", c, out_valid, out_index, out_first, out_last, order_err);
        end
      end
      if ((c >= 1 && c <= 12 && out_valid !== 1'b1) || (c == 13 && out_valid !== 1'b0)) begin
        checks++; failures++;
        $display("FAIL single_timing c=%0d got vld=%b", c, out_valid);
      end
      if (in_valid && in_ready) push_frame();
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      failures++; $display("FAIL single_drained got left=%0d exp 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    int hs;
    hs = 0;
    q.delete();
    for (int c = 0; c < 40; c++) begin
      in_valid = (c == 0); out_ready = ((c % 3) == 0);
      if (c == 0) for (int i = 0; i < 12; i++) sv[i] = 32'(100 + i);
      #1;
      exp_rdy = !rst && (!out_valid || (out_ready && q.size() > 0 && q[0].idx == 4'd11));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_index !== q[0].idx || out_first !== (q[0].idx == 4'd0) ||
            out_last !== (q[0].idx == 4'd11) || order_err !== (q[0].err && q[0].idx == 4'd11)) begin
          failures++;
          $display("FAIL bp_beat c=%0d rdy=%b got d=%0d i=%0d exp d=%0d i=%0d", c, out_ready, out_data, out_index, q[0].d, q[0].idx);
        end
        if (out_ready) begin void'(q.pop_front()); hs++; end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_index !== 4'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
          failures++;
          $display("FAIL bp_idle c=%0d got vld=%b i=%0d exp 0", c, out_valid, out_index);
        end
      end
      if (in_valid && in_ready) push_frame();
      @(negedge clk);
    end
    checks++;
    if (hs != 12 || q.size() != 0) begin
      failures++; $display("FAIL bp_count got hs=%0d left=%0d exp 12 0", hs, q.size());
    end
  endtask

  task automatic test_back_to_back();
    int caps;
    int cap_b;
    caps = 0; cap_b = -1;
    q.delete();
    for (int c = 0; c < 26; c++) begin
      in_valid = (caps < 2); out_ready = 1'b1;
      for (int i = 0; i < 12; i++) sv[i] = (caps == 0) ? 32'(i) : 32'(50 + i);
      #1;
      exp_rdy = !rst && (!out_valid || (out_ready && q.size() > 0 && q[0].idx == 4'd11));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL b2b_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_index !== q[0].idx || out_first !== (q[0].idx == 4'd0) ||
            out_last !== (q[0].idx == 4'd11)) begin
          failures++;
          $display("FAIL b2b_beat c=%0d got d=%0d i=%0d exp d=%0d i=%0d", c, out_data, out_index, q[0].d, q[0].idx);
        end
        void'(q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_index !== 4'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle c=%0d got vld=%b i=%0d exp 0", c, out_valid, out_index);
        end
      end
      if ((c >= 1 && c <= 24 && out_valid !== 1'b1) || (c == 25 && out_valid !== 1'b0)) begin
        checks++; failures++;
        $display("FAIL b2b_bubble c=%0d got vld=%b", c, out_valid);
      end
      if (in_valid && in_ready) begin
        push_frame(); caps++;
        if (caps == 2) cap_b = c;
      end
      @(negedge clk);
    end
    checks++;
    if (cap_b != 12) begin
      failures++; $display("FAIL b2b_bypass got cycle=%0d exp 12", cap_b);
    end
  endtask

  task automatic test_midreset();
    int first_idx;
    first_idx = -1;
    q.delete();
    for (int c = 0; c < 22; c++) begin
      rst = (c == 7);
      in_valid = (c == 0 || c == 8);
      out_ready = (c != 7);
      for (int i = 0; i < 12; i++) sv[i] = (c < 8) ? 32'(200 + i) : 32'd7;
      #1;
      exp_rdy = !rst && (!out_valid || (out_ready && q.size() > 0 && q[0].idx == 4'd11));
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL mrst_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy);
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_index !== q[0].idx || out_first !== (q[0].idx == 4'd0) ||
            out_last !== (q[0].idx == 4'd11)) begin
          failures++;
          $display("FAIL mrst_beat c=%0d got d=%0d i=%0d exp d=%0d i=%0d", c, out_data, out_index, q[0].d, q[0].idx);
        end
        if (c == 9) first_idx = int'(out_index);
        if (out_ready) void'(q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || out_index !== 4'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin
          failures++;
          $display("FAIL mrst_idle c=%0d got vld=%b i=%0d exp 0", c, out_valid, out_index);
        end
      end
      if (c == 8) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          failures++; $display("FAIL mrst_after got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
      end
      if (c == 7) q.delete();
      if (in_valid && in_ready) push_frame();
      @(negedge clk);
    end
    checks++;
    if (first_idx != 0 || q.size() != 0) begin
      failures++; $display("FAIL mrst_restart got idx=%0d left=%0d exp 0 0", first_idx, q.size());
    end
  endtask

  task automatic test_check();
    int caps;
    int err_cnt;
    int err_cyc;
    int exp_cnt;
    caps = 0; err_cnt = 0; err_cyc = -1;
`ifdef SORT_DRAIN_CHECK_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    q.delete();
    for (int c = 0; c < 26; c++) begin
      in_valid = (caps < 2); out_ready = 1'b1;
      for (int i = 0; i < 12; i++) sv[i] = (caps == 0) ? 32'(2 * i) : 32'(1000 + i);
      if (caps == 0) begin sv[4] = 32'd9; sv[5] = 32'd3; end
      #1;
      if (out_valid === 1'b1 && q.size() > 0) begin
        checks++;
        if (out_data !== q[0].d || out_index !== q[0].idx || order_err !== (q[0].err && q[0].idx == 4'd11)) begin
          failures++;
          $display("FAIL chk_beat c=%0d got d=%0d i=%0d e=%b exp d=%0d i=%0d e=%b", c, out_data, out_index, order_err, q[0].d, q[0].idx, q[0].err && q[0].idx == 4'd11);
        end
        void'(q.pop_front());
      end else begin
        checks++;
        if (out_valid !== 1'b0 || order_err !== 1'b0) begin
          failures++; $display("FAIL chk_idle c=%0d got vld=%b e=%b exp 0 0", c, out_valid, order_err);
        end
      end
      if (order_err === 1'b1) begin err_cnt++; err_cyc = c; end
      if (in_valid && in_ready) begin push_frame(); caps++; end
      @(negedge clk);
    end
    checks++;
    if (err_cnt != exp_cnt || (exp_cnt == 1 && err_cyc != 12)) begin
      failures++; $display("FAIL chk_count got n=%0d cyc=%0d exp n=%0d", err_cnt, err_cyc, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_midreset();
    test_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
